mux4_32b: RTL and testbench

- Registered 4-to-1 word selector for the datapath.
- Picks one of four 32-bit operands using a 2-bit control code.
- Presents the chosen word on a registered output one clock later.
- Used wherever the datapath steers operands, such as ALU source, writeback source and PC source, so the following stage sees a clean, glitch-free value.

---
 rtl/mux4_32b.sv | 89 ++++++++
 tb/tb_mux4_32b.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_32b.sv
// ----------------------------------------------------------------------------
// mux4_32b
//   Registered 4-to-1 word selector for the datapath. One of four operands is
//   chosen by a 2-bit control code. The chosen word appears on a registered
//   output one clock later, so the next stage sees a clean, glitch-free value.
//
// Parameters
//   WIDTH      data width of each operand and of the output (any WIDTH >= 1)
//
// Ports
//   clk        rising-edge clock, sole clock of the block
//   rst        synchronous active-high reset (clears out, out_valid, sel_q)
//   input0..3  operands, selected by control = 00 / 01 / 10 / 11
//   control    select code
//   in_valid   qualifies operands and control this cycle
//   out        registered selected word (holds while in_valid is low)
//   out_valid  registered in_valid; out is meaningful when high
//   sel_q      control code that produced the current out
// ----------------------------------------------------------------------------
module mux4_32b #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input0,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [WIDTH-1:0] input3,
    input  logic [1:0]       control,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [1:0]       sel_q
);

    // Combinational selection, built one bit lane at a time as a two-level
    // tree: control[0] picks within each pair, control[1] picks the pair.
    logic [WIDTH-1:0] sel_word;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_lane
            logic lo_bit;
            logic hi_bit;
            assign lo_bit        = control[0] ? input1[gi] : input0[gi];
            assign hi_bit        = control[0] ? input3[gi] : input2[gi];
            assign sel_word[gi]  = control[1] ? hi_bit : lo_bit;
        end
    endgenerate

    // Registered state and its next-state values.
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [1:0]       sel_reg_q;
    logic [1:0]       sel_reg_d;

    // Word and code only update on a qualified cycle; idle cycles hold them
    // so downstream logic sees a stable value, while out_valid simply
    // follows in_valid.
    always_comb begin
        out_d       = out_q;
        sel_reg_d   = sel_reg_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d     = sel_word;
            sel_reg_d = control;
        end
    end

    // Reset takes priority over any pending selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sel_reg_q   <= 2'b00;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sel_reg_q   <= sel_reg_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sel_q     = sel_reg_q;

endmodule

// File: tb/tb_mux4_32b.sv
// ----------------------------------------------------------------------------
// tb_mux4_32b
//   Self-checking bench for mux4_32b. A behavioural model (operand array
//   indexed by the control code, plus hold/reset rules) predicts out,
//   out_valid and sel_q after every rising edge; each scenario task compares
//   the DUT against the model and against fixed expected constants.
// ----------------------------------------------------------------------------
module tb_mux4_32b;

    logic        clk;
    logic        rst;
    logic [31:0] in_w [4];
    logic [1:0]  control;
    logic        in_valid;
    logic [31:0] out;
    logic        out_valid;
    logic [1:0]  sel_q;

    // Model state
    logic [31:0] m_out;
    logic        m_valid;
    logic [1:0]  m_sel;

    int checks = 0;
    int errors = 0;

    mux4_32b #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .input0    (in_w[0]),
        .input1    (in_w[1]),
        .input2    (in_w[2]),
        .input3    (in_w[3]),
        .control   (control),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .sel_q     (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock: update the model from the values present at the
    // edge, then settle 1 time unit before anything is sampled.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_out   = 32'h0;
            m_valid = 1'b0;
            m_sel   = 2'b00;
        end else if (in_valid) begin
            m_out   = in_w[control];
            m_sel   = control;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        $display("txn t=%0t rst=%0b in_valid=%0b control=%0d out=%h out_valid=%0b sel_q=%0d",
                 $time, rst, in_valid, control, out, out_valid, sel_q);
    endtask

    task automatic set_fixed_data();
        in_w[0] = 32'h55555555;
        in_w[1] = 32'h0000FFFF;
        in_w[2] = 32'hFFFF0000;
        in_w[3] = 32'hFFFFFFFF;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst      = 1'b1;
            in_valid = 1'b1;
            control  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) in_w[k] = $urandom;
            tick();
            checks++;
            if (out !== 32'h0) begin
                errors++; $display("FAIL reset_out got=%h exp=%h", out, 32'h0);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid got=%b exp=0", out_valid);
            end
            checks++;
            if (sel_q !== 2'b00) begin
                errors++; $display("FAIL reset_sel got=%0d exp=0", sel_q);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        logic [1:0]  codes [5];
        logic [31:0] words [5];
        codes = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        words = '{32'h55555555, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 32'h55555555};
        set_fixed_data();
        for (int s = 0; s < 5; s++) begin
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                in_valid = 1'b1;
                control  = codes[s];
                tick();
                checks++;
                if (out !== words[s] || out !== m_out) begin
                    errors++; $display("FAIL sweep_out step=%0d got=%h exp=%h", s, out, words[s]);
                end
                checks++;
                if (sel_q !== codes[s] || out_valid !== 1'b1) begin
                    errors++; $display("FAIL sweep_ctl step=%0d got sel=%0d valid=%b exp sel=%0d valid=1",
                                       s, sel_q, out_valid, codes[s]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  seq [8];
        logic [31:0] exp_w;
        seq = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
        set_fixed_data();
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            in_valid = 1'b1;
            control  = seq[s];
            // Before the edge, out still shows the previous selection.
            if (s > 0) begin
                exp_w = in_w[seq[s-1]];
                checks++;
                if (out !== exp_w) begin
                    errors++; $display("FAIL b2b_prev step=%0d got=%h exp=%h", s, out, exp_w);
                end
            end
            tick();
            exp_w = in_w[seq[s]];
            checks++;
            if (out !== exp_w || sel_q !== seq[s] || out_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_out step=%0d got=%h sel=%0d valid=%b exp=%h sel=%0d valid=1",
                                   s, out, sel_q, out_valid, exp_w, seq[s]);
            end
        end
    endtask

    task automatic test_hold();
        set_fixed_data();
        @(negedge clk);
        in_valid = 1'b1;
        control  = 2'b10;
        tick();
        checks++;
        if (out !== 32'hFFFF0000) begin
            errors++; $display("FAIL hold_load got=%h exp=%h", out, 32'hFFFF0000);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            control  = 2'b01;
            in_w[1]  = $urandom;
            tick();
            checks++;
            if (out !== 32'hFFFF0000 || sel_q !== 2'b10 || out_valid !== 1'b0) begin
                errors++; $display("FAIL hold_idle cyc=%0d got=%h sel=%0d valid=%b exp=%h sel=2 valid=0",
                                   i, out, sel_q, out_valid, 32'hFFFF0000);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        tick();
        checks++;
        if (out !== in_w[1] || sel_q !== 2'b01 || out_valid !== 1'b1) begin
            errors++; $display("FAIL hold_resume got=%h sel=%0d valid=%b exp=%h sel=1 valid=1",
                               out, sel_q, out_valid, in_w[1]);
        end
    endtask

    task automatic test_isolation();
        in_w[1] = 32'hA5A5A5A5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            control  = 2'b01;
            in_w[0]  = $urandom;
            in_w[2]  = $urandom;
            in_w[3]  = $urandom;
            tick();
            checks++;
            if (out !== 32'hA5A5A5A5) begin
                errors++; $display("FAIL isolation cyc=%0d got=%h exp=%h", i, out, 32'hA5A5A5A5);
            end
        end
    endtask

    task automatic test_reset_midstream();
        set_fixed_data();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            control  = 2'b11;
            tick();
        end
        checks++;
        if (out !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL midrst_pre got=%h exp=%h", out, 32'hFFFFFFFF);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (out !== 32'h0 || out_valid !== 1'b0 || sel_q !== 2'b00) begin
            errors++; $display("FAIL midrst_clear got=%h valid=%b sel=%0d exp=0 valid=0 sel=0",
                               out, out_valid, sel_q);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (out !== 32'hFFFFFFFF || out_valid !== 1'b1 || sel_q !== 2'b11) begin
            errors++; $display("FAIL midrst_resume got=%h valid=%b sel=%0d exp=%h valid=1 sel=3",
                               out, out_valid, sel_q, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 19) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            control  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) in_w[k] = $urandom;
            tick();
            checks++;
            if (out !== m_out || out_valid !== m_valid || sel_q !== m_sel) begin
                errors++; $display("FAIL random cyc=%0d got=%h valid=%b sel=%0d exp=%h valid=%b sel=%0d",
                                   i, out, out_valid, sel_q, m_out, m_valid, m_sel);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        control  = 2'b00;
        for (int k = 0; k < 4; k++) in_w[k] = 32'h0;
        m_out    = 32'h0;
        m_valid  = 1'b0;
        m_sel    = 2'b00;

        test_reset();
        test_sweep();
        test_back_to_back();
        test_hold();
        test_isolation();
        test_reset_midstream();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
